pipeline_ctrl: RTL

//   Drives the enable/clear pins of the five 32-bit pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Detects load-use hazards.
//   - Flushes on taken branches.
//   - Freezes the front end during multi-cycle mul/div.
//   - Halts on syscall.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 20 ++
 rtl/pipeline_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared CPU control types and pipeline-stage index constants       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Stage indices, shared with the datapath top for its register arrays.
  localparam int STAGE_PC    = 0;
  localparam int STAGE_IFID  = 1;
  localparam int STAGE_IDEX  = 2;
  localparam int STAGE_EXMEM = 3;
  localparam int STAGE_MEMWB = 4;
  localparam int NUM_STAGES  = 5;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_use_detect : flags an ID-stage read of a register a load in EX writes  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);

  assign hazard = ex_memread && (ex_rd != REG_ZERO) &&
                  ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_ctrl : enable/clear sequencing for the five pipeline registers    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_LAT = 4,   // legal range 1..15
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch,
  input  logic             md_start,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             halted,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NUM_STAGES-1:0]          en_vec;
  logic [NUM_STAGES-1:STAGE_IFID] clr_vec;
  logic                           branch_flush;
  logic                           load_use;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .hazard     (load_use)
  );

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    en_vec       = '1;
    clr_vec      = '0;
    branch_flush = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          en_vec  = '0;
          state_d = ST_HALT;
        end else if (md_start) begin
          en_vec[STAGE_PC]    = 1'b0;
          en_vec[STAGE_IFID]  = 1'b0;
          en_vec[STAGE_IDEX]  = 1'b0;
          clr_vec[STAGE_EXMEM] = 1'b1;
          // md_start itself is the first freeze cycle, so the counter holds the rest.
          if (MD_LAT > 1) begin
            state_d  = ST_MD_BUSY;
            md_cnt_d = MD_LOAD;
          end
        end else if (ex_branch) begin
          clr_vec[STAGE_IFID] = 1'b1;
          clr_vec[STAGE_IDEX] = 1'b1;
          branch_flush        = 1'b1;
        end else if (load_use) begin
          en_vec[STAGE_PC]    = 1'b0;
          en_vec[STAGE_IFID]  = 1'b0;
          clr_vec[STAGE_IDEX] = 1'b1;
        end
      end

      ST_MD_BUSY: begin
        en_vec[STAGE_PC]     = 1'b0;
        en_vec[STAGE_IFID]   = 1'b0;
        en_vec[STAGE_IDEX]   = 1'b0;
        clr_vec[STAGE_EXMEM] = 1'b1;
        md_cnt_d             = md_cnt_q - 4'd1;
        if (md_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_HALT: begin
        en_vec = '0;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_HALT) && !en_vec[STAGE_PC]) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (branch_flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset drives every register into clear without enabling it.
  assign pc_en     = clear_n & en_vec[STAGE_PC];
  assign ifid_en   = clear_n & en_vec[STAGE_IFID];
  assign idex_en   = clear_n & en_vec[STAGE_IDEX];
  assign exmem_en  = clear_n & en_vec[STAGE_EXMEM];
  assign memwb_en  = clear_n & en_vec[STAGE_MEMWB];
  assign ifid_clr  = ~clear_n | clr_vec[STAGE_IFID];
  assign idex_clr  = ~clear_n | clr_vec[STAGE_IDEX];
  assign exmem_clr = ~clear_n | clr_vec[STAGE_EXMEM];
  assign memwb_clr = ~clear_n | clr_vec[STAGE_MEMWB];
  assign halted    = clear_n & (state_q == ST_HALT);
  assign md_busy   = clear_n & (state_q == ST_MD_BUSY);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire
